// File: rtl/pll_cfg_ctrl.sv
// pll_cfg_ctrl
// Host-side sequencer for the iCE40UP PLL serial configuration port.
// A request holds the PLL in reset with bypass on and shifts a new
// configuration word in on SDI. The old word is captured from SDO during
// the same shift. Reset is then released and the controller waits for
// lock, with a timeout.
// All outputs are registered. The FSM is a state register plus one
// combinational next-value process.
module pll_cfg_ctrl #(
  parameter int CFG_BITS     = 26,
  parameter int SCLK_DIV     = 4,
  parameter int RESET_HOLD   = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                start,
  input  logic [CFG_BITS-1:0] cfg_data,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [CFG_BITS-1:0] rd_data,
  output logic                PLL_SCLK,
  output logic                PLL_SDI,
  input  logic                PLL_SDO,
  output logic                PLL_RESETB,
  output logic                PLL_BYPASS,
  input  logic                PLL_LOCK
);

  localparam int HOLD_W = $clog2(RESET_HOLD) + 1;
  localparam int DIV_W  = $clog2(2 * SCLK_DIV) + 1;
  localparam int BIT_W  = $clog2(CFG_BITS) + 1;
  localparam int LOCK_W = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [DIV_W-1:0]  DIV_RISE  = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(2 * SCLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(CFG_BITS - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HOLD_RST  = 3'd1,
    SHIFT     = 3'd2,
    RELEASE   = 3'd3,
    WAIT_LOCK = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t              state_reg, state_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [DIV_W-1:0]    div_cnt_reg, div_cnt_next;
  logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [LOCK_W-1:0]   lock_cnt_reg, lock_cnt_next;
  logic [CFG_BITS-1:0] cfg_reg, cfg_next;
  logic [CFG_BITS-1:0] rd_reg, rd_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                error_reg, error_next;
  logic                sclk_reg, sclk_next;
  logic                sdi_reg, sdi_next;
  logic                resetb_reg, resetb_next;
  logic                bypass_reg, bypass_next;
  logic                lock_meta_reg, lock_sync_reg;

  // Bring the asynchronous PLL lock indication into the CLK domain.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lock_meta_reg <= 1'b0;
      lock_sync_reg <= 1'b0;
    end else begin
      lock_meta_reg <= PLL_LOCK;
      lock_sync_reg <= lock_meta_reg;
    end
  end

  // State and output registers. These return to their idle values
  // immediately on RESET, so a partial shift is simply abandoned.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
      div_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      lock_cnt_reg <= '0;
      cfg_reg      <= '0;
      rd_reg       <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
      sclk_reg     <= 1'b0;
      sdi_reg      <= 1'b0;
      resetb_reg   <= 1'b0;
      bypass_reg   <= 1'b1;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      div_cnt_reg  <= div_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      lock_cnt_reg <= lock_cnt_next;
      cfg_reg      <= cfg_next;
      rd_reg       <= rd_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
      sclk_reg     <= sclk_next;
      sdi_reg      <= sdi_next;
      resetb_reg   <= resetb_next;
      bypass_reg   <= bypass_next;
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle
  // ahead, so each registered value appears in the cycle it belongs to.
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    div_cnt_next  = div_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    lock_cnt_next = lock_cnt_reg;
    cfg_next      = cfg_reg;
    rd_next       = rd_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    error_next    = error_reg;
    sclk_next     = sclk_reg;
    sdi_next      = sdi_reg;
    resetb_next   = resetb_reg;
    bypass_next   = bypass_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          cfg_next      = cfg_data;
          error_next    = 1'b0;
          busy_next     = 1'b1;
          resetb_next   = 1'b0;
          bypass_next   = 1'b1;
          hold_cnt_next = '0;
          state_next    = HOLD_RST;
        end
      end

      HOLD_RST: begin
        if (hold_cnt_reg == HOLD_LAST) begin
          // Present the MSB on the first low cycle of bit period 0.
          div_cnt_next = '0;
          bit_cnt_next = '0;
          sclk_next    = 1'b0;
          sdi_next     = cfg_reg[CFG_BITS-1];
          state_next   = SHIFT;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end

      SHIFT: begin
        if (div_cnt_reg == DIV_RISE) begin
          // SCLK rises on this edge. SDO still holds the PLL's current
          // bit because the PLL shifts on that same rising edge.
          sclk_next    = 1'b1;
          rd_next      = {rd_reg[CFG_BITS-2:0], PLL_SDO};
          div_cnt_next = div_cnt_reg + 1'b1;
        end else if (div_cnt_reg == DIV_LAST) begin
          sclk_next = 1'b0;
          if (bit_cnt_reg == BIT_LAST) begin
            sdi_next    = 1'b0;
            resetb_next = 1'b1;
            state_next  = RELEASE;
          end else begin
            div_cnt_next = '0;
            bit_cnt_next = bit_cnt_reg + 1'b1;
            cfg_next     = {cfg_reg[CFG_BITS-2:0], 1'b0};
            sdi_next     = cfg_reg[CFG_BITS-2];
          end
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end

      RELEASE: begin
        lock_cnt_next = '0;
        state_next    = WAIT_LOCK;
      end

      WAIT_LOCK: begin
        // Lock takes priority over the timeout in the same cycle.
        if (lock_sync_reg) begin
          done_next   = 1'b1;
          busy_next   = 1'b0;
          error_next  = 1'b0;
          bypass_next = 1'b0;
          state_next  = DONE;
        end else if (lock_cnt_reg == LOCK_LAST) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          error_next = 1'b1;
          state_next = DONE;
        end else begin
          lock_cnt_next = lock_cnt_reg + 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign error      = error_reg;
  assign rd_data    = rd_reg;
  assign PLL_SCLK   = sclk_reg;
  assign PLL_SDI    = sdi_reg;
  assign PLL_RESETB = resetb_reg;
  assign PLL_BYPASS = bypass_reg;

endmodule

// File: tb/tb_pll_cfg_ctrl.sv
// tb_pll_cfg_ctrl
// Directed bench for pll_cfg_ctrl with a behavioural PLL configuration
// chain. The chain is a 26-bit shift register clocked by PLL_SCLK and
// preloaded with 26'h1234567.
module tb_pll_cfg_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic [25:0] cfg_data = '0;
  logic        busy, done, error;
  logic [25:0] rd_data;
  logic        PLL_SCLK, PLL_SDI, PLL_SDO, PLL_RESETB, PLL_BYPASS;
  logic        PLL_LOCK = 1'b0;

  int n_compared = 0;
  int n_mismatch = 0;

  pll_cfg_ctrl #(
    .CFG_BITS(26), .SCLK_DIV(2), .RESET_HOLD(4), .LOCK_TIMEOUT(100)
  ) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .error(error), .rd_data(rd_data),
    .PLL_SCLK(PLL_SCLK), .PLL_SDI(PLL_SDI), .PLL_SDO(PLL_SDO),
    .PLL_RESETB(PLL_RESETB), .PLL_BYPASS(PLL_BYPASS), .PLL_LOCK(PLL_LOCK)
  );

  always #5 CLK = ~CLK;

  // PLL configuration chain model
  logic [25:0] pll_sr = 26'h1234567;
  always @(posedge PLL_SCLK) pll_sr <= {pll_sr[24:0], PLL_SDI};
  assign PLL_SDO = pll_sr[25];

  // Per-cycle observer: SCLK rise timing, busy and RESETB rise cycles
  int   cyc = 0, rises = 0, last_rise = -1000, first_rise = 0;
  int   busy_rise = 0, rstb_rise = 0, spacing_err = 0;
  logic sclk_q = 1'b0, busy_q = 1'b0, rstb_q = 1'b0;
  always @(posedge CLK) begin
    #1;
    cyc++;
    if (PLL_SCLK && !sclk_q) begin
      if (cyc - last_rise < 50) begin
        if (cyc - last_rise != 4) spacing_err++;
      end else begin
        first_rise = cyc;
      end
      last_rise = cyc;
      rises++;
    end
    if (busy && !busy_q) busy_rise = cyc;
    if (PLL_RESETB && !rstb_q) rstb_rise = cyc;
    sclk_q = PLL_SCLK;
    busy_q = busy;
    rstb_q = PLL_RESETB;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  // Pulse start for one cycle; busy rises and error clears on acceptance.
  task automatic do_start(input logic [25:0] w);
    start = 1'b1;
    cfg_data = w;
    step(1);
    start = 1'b0;
    $display("start cfg=0x%07h busy=%0b error=%0b", w, busy, error);
    check("busy_on_start", {31'd0, busy}, 32'd1);
    check("error_cleared", {31'd0, error}, 32'd0);
  endtask

  task automatic wait_resetb();
    int n = 0;
    while (!PLL_RESETB && n < 400) begin
      step(1);
      n++;
    end
    check("resetb_release", {31'd0, PLL_RESETB}, 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 400) begin
      step(1);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    $display("done after %0d cycles: error=%0b bypass=%0b rd_data=0x%07h chain=0x%07h",
             n, error, PLL_BYPASS, rd_data, pll_sr);
  endtask

  initial begin
    int n;
    int base;

    // Reset values
    step(3);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_rd_data", {6'd0, rd_data}, 32'd0);
    check("rst_sclk", {31'd0, PLL_SCLK}, 32'd0);
    check("rst_sdi", {31'd0, PLL_SDI}, 32'd0);
    check("rst_resetb", {31'd0, PLL_RESETB}, 32'd0);
    check("rst_bypass", {31'd0, PLL_BYPASS}, 32'd1);
    RESET = 1'b0;
    step(2);

    // Run 1/2: shift 2AAAAAA, lock 10 cycles after RESETB rises
    base = rises;
    do_start(26'h2AAAAAA);
    wait_resetb();
    check("bypass_at_release", {31'd0, PLL_BYPASS}, 32'd1);
    check("sdi_after_shift", {31'd0, PLL_SDI}, 32'd0);
    check("sclk_after_shift", {31'd0, PLL_SCLK}, 32'd0);
    check("sclk_rises_1", rises - base, 32'd26);
    check("hold_to_first_rise", first_rise - busy_rise, 32'd6);
    check("sclk_spacing", spacing_err, 32'd0);
    check("last_rise_to_release", rstb_rise - last_rise, 32'd2);
    step(10);
    PLL_LOCK = 1'b1;
    wait_done(n);
    check("lock_to_done", n, 32'd3);
    check("error_on_lock", {31'd0, error}, 32'd0);
    check("bypass_on_lock", {31'd0, PLL_BYPASS}, 32'd0);
    check("busy_with_done", {31'd0, busy}, 32'd0);
    check("rd_data_1", {6'd0, rd_data}, 32'h1234567);
    check("chain_1", {6'd0, pll_sr}, 32'h2AAAAAA);
    step(1);
    check("done_pulse_1", {31'd0, done}, 32'd0);

    // Run 3: no lock, timeout after 100 cycles in WAIT_LOCK
    PLL_LOCK = 1'b0;
    step(3);
    base = rises;
    do_start(26'h0F0F0F0);
    wait_resetb();
    wait_done(n);
    check("timeout_cycles", n, 32'd101);
    check("error_on_timeout", {31'd0, error}, 32'd1);
    check("bypass_on_timeout", {31'd0, PLL_BYPASS}, 32'd1);
    check("rd_data_3", {6'd0, rd_data}, 32'h2AAAAAA);
    check("chain_3", {6'd0, pll_sr}, 32'h0F0F0F0);
    check("sclk_rises_3", rises - base, 32'd26);
    step(5);
    check("error_held", {31'd0, error}, 32'd1);
    check("done_pulse_3", {31'd0, done}, 32'd0);

    // Run 4: start with cfg_data=0 at bit 5 of SHIFT is ignored
    base = rises;
    do_start(26'h2AAAAAA);
    n = 0;
    while (rises - base < 5 && n < 400) begin
      step(1);
      n++;
    end
    start = 1'b1;
    cfg_data = '0;
    step(1);
    start = 1'b0;
    check("busy_ignored_start", {31'd0, busy}, 32'd1);
    wait_resetb();
    PLL_LOCK = 1'b1;
    wait_done(n);
    check("sclk_rises_4", rises - base, 32'd26);
    check("chain_4", {6'd0, pll_sr}, 32'h2AAAAAA);
    check("rd_data_4", {6'd0, rd_data}, 32'h0F0F0F0);
    check("error_4", {31'd0, error}, 32'd0);

    // Run 5: RESET during bit 10 of SHIFT, after 10 rises
    PLL_LOCK = 1'b0;
    step(3);
    base = rises;
    do_start(26'h3FFFFFF);
    n = 0;
    while (!(rises - base == 10 && !PLL_SCLK) && n < 400) begin
      step(1);
      n++;
    end
    check("sdi_before_reset", {31'd0, PLL_SDI}, 32'd1);
    #1;
    RESET = 1'b1;
    #1;
    $display("async reset mid-shift: busy=%0b sclk=%0b sdi=%0b rd_data=0x%07h", busy, PLL_SCLK,
             PLL_SDI, rd_data);
    check("areset_busy", {31'd0, busy}, 32'd0);
    check("areset_sclk", {31'd0, PLL_SCLK}, 32'd0);
    check("areset_sdi", {31'd0, PLL_SDI}, 32'd0);
    check("areset_rd_data", {6'd0, rd_data}, 32'd0);
    check("areset_resetb", {31'd0, PLL_RESETB}, 32'd0);
    check("areset_bypass", {31'd0, PLL_BYPASS}, 32'd1);
    step(2);
    RESET = 1'b0;
    step(2);
    check("partial_rises", rises - base, 32'd10);
    check("partial_chain", {6'd0, pll_sr}, 32'h2AAABFF);

    // Run 6: new start after reset; cfg_data changes one cycle after start
    base = rises;
    do_start(26'h1555555);
    cfg_data = '0;
    wait_resetb();
    PLL_LOCK = 1'b1;
    wait_done(n);
    check("rd_data_6", {6'd0, rd_data}, 32'h2AAABFF);
    check("chain_6", {6'd0, pll_sr}, 32'h1555555);
    check("sclk_rises_6", rises - base, 32'd26);
    check("error_6", {31'd0, error}, 32'd0);
    check("bypass_6", {31'd0, PLL_BYPASS}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
